// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: I2C master SCL generator with clock-stretch detection, timeout and phase strobes.
module i2c_scl_gen #(
    parameter int CNT_W       = 16,
    parameter int STRETCH_MAX = 1000,
    parameter int TO_W        = 16
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             fall_stb,
    output logic             chg_stb,
    output logic             rise_stb,
    output logic             smp_stb,
    output logic             busy,
    output logic             stretching,
    output logic             timeout_err
);
    typedef enum logic [1:0] {IDLE, LOW, STRETCH, HIGH} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(STRETCH_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, h_q, h_d;
    logic [TO_W-1:0]  st_q, st_d;
    logic             to_q, to_d;
    logic             s1_q, scl_sync_q;
    logic [CNT_W-1:0] h_eff, half;
    logic             last, stretch_to;

    assign h_eff      = (div < CNT_W'(2)) ? CNT_W'(2) : div;
    assign half       = h_q >> 1;
    assign last       = cnt_q == h_q - CNT_W'(1);
    assign stretch_to = (STRETCH_MAX != 0) && (st_q == TO_LAST) && !scl_sync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        st_d    = st_q;
        to_d    = en ? to_q : 1'b0;
        case (state_q)
            IDLE: if (en && !to_q) begin
                state_d = LOW;
                cnt_d   = '0;
                h_d     = h_eff;
            end
            LOW: if (last) begin
                state_d = STRETCH;
                cnt_d   = '0;
                st_d    = '0;
            end else cnt_d = cnt_q + CNT_W'(1);
            STRETCH: if (scl_sync_q) state_d = HIGH;
            else if (stretch_to) begin
                state_d = IDLE;
                to_d    = 1'b1;
            end else if (st_q != '1) st_d = st_q + TO_W'(1);
            HIGH: if (last) begin
                cnt_d   = '0;
                state_d = en ? LOW : IDLE;
                h_d     = en ? h_eff : h_q;
            end else cnt_d = cnt_q + CNT_W'(1);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            h_q        <= CNT_W'(2);
            st_q       <= '0;
            to_q       <= 1'b0;
            s1_q       <= 1'b1;
            scl_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_q        <= h_d;
            st_q       <= st_d;
            to_q       <= to_d;
            s1_q       <= scl_in;
            scl_sync_q <= s1_q;
        end
    end

    assign scl_oe      = state_q == LOW;
    assign fall_stb    = state_q == LOW && cnt_q == '0;
    assign chg_stb     = state_q == LOW && cnt_q == half;
    assign rise_stb    = state_q == HIGH && cnt_q == '0;
    assign smp_stb     = state_q == HIGH && cnt_q == half;
    assign busy        = state_q != IDLE;
    assign stretching  = state_q == STRETCH;
    assign timeout_err = to_q;
endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: table-driven and directed checks of i2c_scl_gen.
module tb_i2c_scl_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div = 16'd4;
    logic        scl_in = 1'b1;
    logic        oe, fa, ch, ri, sm, bu, st, to;
    logic        oe_d, fa_d, ch_d, ri_d, sm_d, bu_d, st_d, to_d;
    logic [7:0]  obs, obs_d;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        en;
        logic [15:0] div;
        logic        scl;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    i2c_scl_gen #(.STRETCH_MAX(10)) dut (
        .ref_clk(clk), .reset(reset), .en(en), .div(div), .scl_in(scl_in),
        .scl_oe(oe), .fall_stb(fa), .chg_stb(ch), .rise_stb(ri), .smp_stb(sm),
        .busy(bu), .stretching(st), .timeout_err(to)
    );

    i2c_scl_gen dut_d (
        .ref_clk(clk), .reset(reset), .en(en), .div(div), .scl_in(scl_in),
        .scl_oe(oe_d), .fall_stb(fa_d), .chg_stb(ch_d), .rise_stb(ri_d), .smp_stb(sm_d),
        .busy(bu_d), .stretching(st_d), .timeout_err(to_d)
    );

    // Output vector order: {scl_oe, fall, chg, rise, smp, busy, stretching, timeout_err}
    assign obs   = {oe, fa, ch, ri, sm, bu, st, to};
    assign obs_d = {oe_d, fa_d, ch_d, ri_d, sm_d, bu_d, st_d, to_d};

    function automatic logic [7:0] ev(input bit o, f, c, r, s, b, t, e);
        return {o, f, c, r, s, b, t, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        en     = 1'b0;
        scl_in = 1'b1;
        div    = 16'd4;
        step();
        step();
        chk("reset_state", obs, 8'h00);
        reset = 1'b1;
        step();
        chk("idle_after_release", obs, 8'h00);
    endtask

    task automatic add(input logic e, input logic [15:0] d, input logic s, input logic [7:0] x);
        vec_t v;
        v.en  = e;
        v.div = d;
        v.scl = s;
        v.exp = x;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] p4[9];
        logic [7:0] p2[5];
        p4 = '{8'b11000100, 8'b10000100, 8'b10100100, 8'b10000100, 8'b00000110,
               8'b00010100, 8'b00000100, 8'b00001100, 8'b00000100};
        p2 = '{8'b11000100, 8'b10100100, 8'b00000110, 8'b00010100, 8'b00001100};
        for (int i = 0; i < 18; i++) add(1'b1, 16'd4, 1'b1, p4[i % 9]);
        for (int i = 0; i < 5; i++) add(1'b1, 16'd0, 1'b1, p2[i]);
        for (int i = 0; i < 5; i++) add(1'b1, 16'd1, 1'b1, p2[i]);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            en     = tbl[i].en;
            div    = tbl[i].div;
            scl_in = tbl[i].scl;
            step();
            chk($sformatf("table[%0d]", i), obs, tbl[i].exp);
        end

        // Long stretch on the default instance, well under its timeout
        do_reset();
        en = 1'b1; div = 16'd6; scl_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("s33_low%0d", k), obs_d, ev(1, k == 0, k == 3, 0, 0, 1, 0, 0));
        end
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("s33_str%0d", k), obs_d, 8'b00000110);
        end
        scl_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("s33_sync%0d", k), obs_d, 8'b00000110);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("s33_high%0d", k), obs_d, ev(0, 0, 0, k == 0, k == 3, 1, 0, 0));
        end
        step();
        chk("s33_next_fall", obs_d, 8'b11000100);

        // Stuck-low SCL times out after 10 stretch cycles
        do_reset();
        en = 1'b1; div = 16'd4; scl_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("s34_low%0d", k), obs, ev(1, k == 0, k == 2, 0, 0, 1, 0, 0));
        end
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("s34_str%0d", k), obs, 8'b00000110);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("s34_timeout%0d", k), obs, 8'b00000001);
        end
        en = 1'b0; scl_in = 1'b1;
        step();
        chk("s34_clear", obs, 8'h00);
        en = 1'b1;
        step();
        chk("s34_restart", obs, 8'b11000100);

        // en dropped mid-LOW, then div changed mid-HIGH
        do_reset();
        en = 1'b1; div = 16'd4;
        step();
        chk("s35_l0", obs, 8'b11000100);
        en = 1'b0;
        for (int k = 1; k < 9; k++) begin
            step();
            chk($sformatf("s35_run%0d", k), obs, p4[k]);
        end
        step();
        chk("s35_idle", obs, 8'h00);
        step();
        chk("s35_stay_idle", obs, 8'h00);
        en = 1'b1;
        for (int k = 0; k < 7; k++) step();
        chk("s35_h1", obs, 8'b00000100);
        div = 16'd8;
        step();
        chk("s35_h2_old_h", obs, 8'b00001100);
        step();
        chk("s35_h3_old_h", obs, 8'b00000100);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("s35_newlow%0d", k), obs, ev(1, k == 0, k == 4, 0, 0, 1, 0, 0));
        end
        step();
        chk("s35_new_stretch", obs, 8'b00000110);

        // Reset asserted in HIGH count 2
        do_reset();
        en = 1'b1; div = 16'd4;
        for (int k = 0; k < 8; k++) step();
        chk("s36_h2", obs, 8'b00001100);
        reset = 1'b0;
        step();
        chk("s36_reset", obs, 8'h00);
        reset = 1'b1;
        step();
        chk("s36_first_fall", obs, 8'b11000100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
